// File: rtl/elbeth_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : elbeth_mem_arbiter
// Description : Round-robin sharing of one ELBETH RAM port between fetch (I)
//               and load/store (D), with registered outputs and a ready watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module elbeth_mem_arbiter #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_ready,
    output logic          i_err,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wr,
    output logic [31:0]   d_rdata,
    output logic          d_ready,
    output logic          d_err,
    output logic          mem_enable,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data_in,
    output logic [3:0]    mem_wr,
    input  logic [31:0]   mem_data_out,
    input  logic          mem_ready,
    output logic          busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] c_TIMEOUT_CNT = 4'(TIMEOUT);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;        // 1 = D owns the port, 0 = I
    logic          rr_last_q, rr_last_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          mem_enable_q, mem_enable_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_data_in_q, mem_data_in_d;
    logic [3:0]    mem_wr_q, mem_wr_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic          i_err_q, i_err_d;
    logic          d_err_q, d_err_d;
    logic          busy_q, busy_d;
    logic          w_pick_d;
    logic [3:0]    w_cnt_inc;

    // On contention the side that was not served last wins.
    assign w_pick_d  = d_req & (~i_req | ~rr_last_q);
    assign w_cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_last_d     = rr_last_q;
        cnt_d         = cnt_q;
        mem_enable_d  = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_wr_d      = 4'b0000;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        i_ready_d     = 1'b0;
        d_ready_d     = 1'b0;
        i_err_d       = 1'b0;
        d_err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    state_d       = S_ISSUE;
                    owner_d       = w_pick_d;
                    rr_last_d     = w_pick_d;
                    mem_enable_d  = 1'b1;
                    mem_addr_d    = w_pick_d ? d_addr  : i_addr;
                    mem_data_in_d = w_pick_d ? d_wdata : 32'h0;
                    mem_wr_d      = w_pick_d ? d_wr    : 4'b0000;
                end
            end
            S_ISSUE: begin
                state_d      = S_WAIT;
                cnt_d        = 4'd0;
                mem_enable_d = 1'b1;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    state_d = S_RESP;
                    if (owner_q) begin
                        d_rdata_d = mem_data_out;
                        d_ready_d = 1'b1;
                    end else begin
                        i_rdata_d = mem_data_out;
                        i_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_TIMEOUT_CNT) begin
                        state_d = S_RESP;
                        if (owner_q) begin
                            d_rdata_d = 32'h0;
                            d_ready_d = 1'b1;
                            d_err_d   = 1'b1;
                        end else begin
                            i_rdata_d = 32'h0;
                            i_ready_d = 1'b1;
                            i_err_d   = 1'b1;
                        end
                    end else begin
                        mem_enable_d = 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            rr_last_q     <= 1'b0;
            cnt_q         <= 4'd0;
            mem_enable_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= 32'h0;
            mem_wr_q      <= 4'b0000;
            i_rdata_q     <= 32'h0;
            d_rdata_q     <= 32'h0;
            i_ready_q     <= 1'b0;
            d_ready_q     <= 1'b0;
            i_err_q       <= 1'b0;
            d_err_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            cnt_q         <= cnt_d;
            mem_enable_q  <= mem_enable_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_wr_q      <= mem_wr_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            i_ready_q     <= i_ready_d;
            d_ready_q     <= d_ready_d;
            i_err_q       <= i_err_d;
            d_err_q       <= d_err_d;
            busy_q        <= busy_d;
        end
    end

    assign i_rdata     = i_rdata_q;
    assign i_ready     = i_ready_q;
    assign i_err       = i_err_q;
    assign d_rdata     = d_rdata_q;
    assign d_ready     = d_ready_q;
    assign d_err       = d_err_q;
    assign mem_enable  = mem_enable_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_wr      = mem_wr_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire
